// File: rtl/mul_accum_pkg.sv
// Shared definitions for the shift-and-add multiply-accumulate engine.
//   ma_state_t : FSM state encoding (IDLE / BUSY / DONE)
//   MA_WIDTH   : default operand/result width, matching the divider datapath
//   MA_COUNT_W : bit-step counter width for the default width
package mul_accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ma_state_t;

  localparam int unsigned MA_WIDTH   = 21;
  localparam int unsigned MA_COUNT_W = $clog2(MA_WIDTH + 1);

endpackage

// File: rtl/mul_accum_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into the
// accumulator, then advance multiplicand (left) and multiplier (right).
// Ports:
//   acc, mcand        : 2*WIDTH+1-bit accumulator and shifted multiplicand
//   mplier            : WIDTH-bit remaining multiplier bits
//   acc_next, mcand_next, mplier_next : values after this iteration
module mac_step
  import mul_accum_pkg::*;
#(
  parameter int unsigned WIDTH = MA_WIDTH
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [2*WIDTH:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [2*WIDTH:0] acc_next,
  output logic [2*WIDTH:0] mcand_next,
  output logic [WIDTH-1:0] mplier_next
);

  always_comb begin
    acc_next    = mplier[0] ? acc + mcand : acc;
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
  end

endmodule

// File: rtl/mul_accum.sv
// Sequential multiply-accumulate: opt = ia*ib + ic, one multiplier bit per
// clock, fixed latency. Also used as the divider round-trip self-check.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted in IDLE or in the DONE cycle
//   ia, ib, ic : multiplicand, multiplier, addend (unsigned)
//   busy       : operation in progress
//   done       : one-cycle pulse, opt/ovf valid
//   opt        : low WIDTH bits of the result, held until the next result
//   ovf        : true result does not fit in WIDTH bits
module mul_accum
  import mul_accum_pkg::*;
#(
  parameter int unsigned WIDTH = MA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ia,
  input  logic [WIDTH-1:0] ib,
  input  logic [WIDTH-1:0] ic,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] opt,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  ma_state_t        state;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  logic [2*WIDTH:0] acc_next;
  logic [2*WIDTH:0] mcand_next;
  logic [WIDTH-1:0] mplier_next;
  logic             accept;

  mac_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_next   (acc_next),
    .mcand_next (mcand_next),
    .mplier_next(mplier_next)
  );

  assign accept = start && (state == IDLE || state == DONE);

  // BUSY spans WIDTH step edges plus one finalising edge (count == WIDTH)
  // that publishes the result, giving done at start edge + WIDTH + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      opt    <= '0;
      ovf    <= 1'b0;
    end else if (accept) begin
      state  <= BUSY;
      mcand  <= {{(WIDTH+1){1'b0}}, ia};
      acc    <= {{(WIDTH+1){1'b0}}, ic};
      mplier <= ib;
      count  <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          if (count == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            opt   <= acc[WIDTH-1:0];
            ovf   <= |acc[2*WIDTH:WIDTH];
          end else begin
            acc    <= acc_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            count  <= count + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_accum.sv
// Scoreboard bench for mul_accum: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_accum;

  localparam int unsigned W = 21;
  localparam int unsigned LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] ia, ib, ic;
  logic         busy, done, ovf;
  logic [W-1:0] opt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [W-1:0] opt;
    logic         ovf;
  } exp_t;
  exp_t sb[$];

  mul_accum #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .ia   (ia),
    .ib   (ib),
    .ic   (ic),
    .busy (busy),
    .done (done),
    .opt  (opt),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) check("busy_and_done", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("opt", longint'(opt), longint'(e.opt));
          check("ovf", longint'(ovf), longint'(e.ovf));
        end
      end
    end
  end

  // Drive one request at the next negedge, consumed on the following posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [W-1:0] eo, input logic ev, output int t0);
    exp_t e;
    e.opt = eo;
    e.ovf = ev;
    sb.push_back(e);
    start = 1'b1; ia = a; ib = b; ic = c;
    @(posedge clk);
    #1 t0 = cyc;
  endtask

  // Waits (bounded) for done at a negedge and checks the latency.
  task automatic wait_done(input int t0, input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
    else check({name, "_latency"}, cyc - t0, LAT);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [W-1:0] eo, input logic ev, input string name);
    int t0;
    @(negedge clk);
    issue(a, b, c, eo, ev, t0);
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, name);
  endtask

  initial begin
    int t0;
    #100000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; ia = '0; ib = '0; ic = '0;

    // 1. reset with random activity on inputs
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); ia = W'($urandom); ib = W'($urandom); ic = W'($urandom);
      @(posedge clk);
      #1;
      check("rst_opt", opt, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // 2..4. basic, round trip, zero multiplier, overflow, max
    run_op(21'd7, 21'd6, 21'd0, 21'd42, 1'b0, "basic");
    run_op(21'd1234, 21'd56, 21'd50, 21'd69154, 1'b0, "roundtrip");
    run_op(21'd1234, 21'd0, 21'd99, 21'd99, 1'b0, "ib_zero");
    run_op(21'd0, 21'd777, 21'd5, 21'd5, 1'b0, "ia_zero");
    run_op(21'h1FFFFF, 21'd2, 21'd0, 21'h1FFFFE, 1'b1, "ovf");

    // previous result must be held while the next op is busy
    @(negedge clk);
    issue(21'd1, 21'd1, 21'd0, 21'd1, 1'b0, t0);
    repeat (5) @(negedge clk);
    start = 1'b0;
    check("held_opt", opt, 21'h1FFFFE);
    check("held_ovf", ovf, 1);
    check("held_busy", busy, 1);
    wait_done(t0, "ovf_clear");

    run_op(21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF, 21'd0, 1'b1, "max");

    // 5. start held through BUSY with other operands: ignored
    @(negedge clk);
    issue(21'd100, 21'd200, 21'd5, 21'd20005, 1'b0, t0);
    ia = 21'd9; ib = 21'd9; ic = 21'd9;
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_done(t0, "held_start");

    // back-to-back: start in the done cycle
    @(negedge clk);
    issue(21'd1000, 21'd1000, 21'd0, 21'd1000000, 1'b0, t0);
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, "b2b_first");
    issue(21'd2000, 21'd2000, 21'd7, 21'd1902855, 1'b1, t0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done(t0, "b2b_second");

    // 6. reset mid-operation aborts with no done
    @(negedge clk);
    issue(21'd55, 21'd66, 21'd0, 21'd3630, 1'b0, t0);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    check("abort_opt", opt, 0);
    check("abort_ovf", ovf, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run_op(21'd3, 21'd5, 21'd1, 21'd16, 1'b0, "after_abort");

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
